button_pulse_gen: RTL and testbench

- Front-end stage feeding the up/down counter's acrescer/decrecer inputs from two raw mechanical push-buttons.
- Synchronises each button, debounces it and emits a single-cycle increment/decrement pulse per accepted press.
- Output pulses connect directly to the counter's acrescer/decrecer inputs; the debounced levels go to status LEDs.

---
 rtl/button_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_button_pulse_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: two push-buttons in, one-cycle increment/decrement
// pulses out for the up/down counter, plus debounced levels for status LEDs.
// Each button goes through a two-flop synchroniser and a debounce counter;
// an accepted press produces one registered pulse. Pulses from both buttons
// landing in the same cycle cancel, so acrescer and decrecer are exclusive.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat while exactly one
// button is held (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD).
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_down,
    output logic acrescer,
    output logic decrecer,
    output logic up_held,
    output logic down_held
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter values that would make the counters meaningless.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_pulse_gen: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
    end

    logic             up_s1, up_s2;
    logic             down_s1, down_s2;
    logic             up_stable, down_stable;
    logic [CNT_W-1:0] up_cnt, down_cnt;
    logic             up_accept, down_accept;
    logic             up_raw, down_raw;

    // A change is accepted once it has persisted for DEBOUNCE_CYCLES samples.
    assign up_accept   = (up_s2 != up_stable) && (up_cnt == CNT_LAST);
    assign down_accept = (down_s2 != down_stable) && (down_cnt == CNT_LAST);

    // Two-flop synchronisers; reset value 0 matches the released state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_s1   <= 1'b0;
            up_s2   <= 1'b0;
            down_s1 <= 1'b0;
            down_s2 <= 1'b0;
        end else begin
            up_s1   <= btn_up;
            up_s2   <= up_s1;
            down_s1 <= btn_down;
            down_s2 <= down_s1;
        end
    end

    // Up-button debounce: any return to the stable level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_cnt    <= '0;
            up_stable <= 1'b0;
        end else if (up_s2 == up_stable) begin
            up_cnt <= '0;
        end else if (up_accept) begin
            up_cnt    <= '0;
            up_stable <= up_s2;
        end else begin
            up_cnt <= up_cnt + CNT_W'(1);
        end
    end

    // Down-button debounce, same rules as the up button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_cnt    <= '0;
            down_stable <= 1'b0;
        end else if (down_s2 == down_stable) begin
            down_cnt <= '0;
        end else if (down_accept) begin
            down_cnt    <= '0;
            down_stable <= down_s2;
        end else begin
            down_cnt <= down_cnt + CNT_W'(1);
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;
    logic             rpt_run;
    logic             rpt_fire;

    // Count only while exactly one button is held and it is not being released now.
    assign rpt_run  = (up_stable ^ down_stable)
                      && !(up_accept && up_stable)
                      && !(down_accept && down_stable);
    assign rpt_fire = rpt_run && (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST));

    // Repeat timer: initial delay first, then the shorter period once armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (!rpt_run) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    assign up_raw   = (up_accept && up_s2) || (rpt_fire && up_stable);
    assign down_raw = (down_accept && down_s2) || (rpt_fire && down_stable);
`else
    assign up_raw   = up_accept && up_s2;
    assign down_raw = down_accept && down_s2;
`endif

    // Registered pulses; coincident up and down requests cancel each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acrescer <= 1'b0;
            decrecer <= 1'b0;
        end else begin
            acrescer <= up_raw && !down_raw;
            decrecer <= down_raw && !up_raw;
        end
    end

    assign up_held   = up_stable;
    assign down_held = down_stable;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Testbench for button_pulse_gen (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3). Honours AUTO_REPEAT_EN the same way as the design.
module tb_button_pulse_gen;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int unsigned WMASK = ((32'd1 << DC) - 1) << 1;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up;
    logic btn_down;
    logic acrescer;
    logic decrecer;
    logic up_held;
    logic down_held;

    int n_vec = 0;
    int n_err = 0;
    int acr_cnt = 0;
    int dec_cnt = 0;
    bit mon_en = 0;

    // reference model state
    int unsigned hu, hd;
    bit m_uh, m_dh, m_acr, m_dec;
    int m_run;

    typedef struct {
        bit    up;
        bit    down;
        int    cycles;
        int    exp_acr;
        int    exp_dec;
        bit    exp_uh;
        bit    exp_dh;
        string name;
    } vec_t;

    vec_t vecs[10];

    button_pulse_gen #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .acrescer (acrescer),
        .decrecer (decrecer),
        .up_held  (up_held),
        .down_held(down_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected up pulse 'rel' cycles after the initial accepted press.
    function automatic bit up_pulse_expected(input int rel);
        if (rel == 0) return 1'b1;
`ifdef AUTO_REPEAT_EN
        if (rel >= RD && ((rel - RD) % RP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        hu = 0; hd = 0;
        m_uh = 0; m_dh = 0; m_acr = 0; m_dec = 0;
        m_run = 0;
    endtask

    // A change is accepted when the last DC synchronised samples (raw delayed
    // by two cycles) all differ from the stable level.
    task automatic model_step();
        bit acc_u, acc_d, pu, pd;
        acc_u = m_uh ? ((hu & WMASK) == 0) : ((hu & WMASK) == WMASK);
        acc_d = m_dh ? ((hd & WMASK) == 0) : ((hd & WMASK) == WMASK);
        pu = acc_u && !m_uh;
        pd = acc_d && !m_dh;
`ifdef AUTO_REPEAT_EN
        if ((m_uh != m_dh) && !(acc_u && m_uh) && !(acc_d && m_dh)) begin
            m_run++;
            if (m_run >= RD && ((m_run - RD) % RP) == 0) begin
                pu = pu || m_uh;
                pd = pd || m_dh;
            end
        end else begin
            m_run = 0;
        end
`endif
        m_acr = pu && !pd;
        m_dec = pd && !pu;
        if (acc_u) m_uh = !m_uh;
        if (acc_d) m_dh = !m_dh;
        hu = (hu << 1) | int'(btn_up);
        hd = (hd << 1) | int'(btn_down);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Cycle-by-cycle comparison against the model, plus pulse counting.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("model", {acrescer, decrecer, up_held, down_held}, {m_acr, m_dec, m_uh, m_dh});
            check("exclusive", int'(acrescer && decrecer), 0);
            if (acrescer) acr_cnt++;
            if (decrecer) dec_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        btn_up = 0; btn_down = 0; rst_n = 1;
        #3 rst_n = 0;
        #1;
        check("reset_acr", acrescer, 0);
        check("reset_dec", decrecer, 0);
        check("reset_uh", up_held, 0);
        check("reset_dh", down_held, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        mon_en = 1;

        // table-driven level sequences
        vecs[0] = '{0, 0, 8, 0, 0, 0, 0, "idle"};
        vecs[1] = '{1, 0, 9, 1, 0, 1, 0, "press_up"};
        vecs[2] = '{0, 0, 9, 0, 0, 0, 0, "release_up"};
        vecs[3] = '{0, 1, 9, 0, 1, 0, 1, "press_down"};
        vecs[4] = '{1, 1, 9, 1, 0, 1, 1, "up_while_down"};
        vecs[5] = '{0, 0, 9, 0, 0, 0, 0, "release_both"};
        vecs[6] = '{1, 1, 9, 0, 0, 1, 1, "simultaneous"};
        vecs[7] = '{0, 0, 9, 0, 0, 0, 0, "release_simul"};
        vecs[8] = '{1, 0, 3, 0, 0, 0, 0, "glitch_on"};
        vecs[9] = '{0, 0, 6, 0, 0, 0, 0, "glitch_off"};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btn_up = vecs[i].up;
            btn_down = vecs[i].down;
            acr_cnt = 0;
            dec_cnt = 0;
            repeat (vecs[i].cycles - 1) @(negedge clk);
            #1;
            check({vecs[i].name, "_acr"}, acr_cnt, vecs[i].exp_acr);
            check({vecs[i].name, "_dec"}, dec_cnt, vecs[i].exp_dec);
            check({vecs[i].name, "_uh"}, up_held, vecs[i].exp_uh);
            check({vecs[i].name, "_dh"}, down_held, vecs[i].exp_dh);
        end

        // clean press held long: pulse at edge 6, repeats if enabled
        @(negedge clk);
        btn_up = 1;
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk);
            #1;
            check("hold_acr", acrescer, up_pulse_expected(e - 6));
            check("hold_dec", decrecer, 0);
            check("hold_uh", up_held, int'(e >= 6));
        end
        @(negedge clk);
        btn_up = 0;
        repeat (10) @(negedge clk);

        // bounce on btn_down, then steady high
        for (int b = 0; b < 8; b++) begin
            btn_down = (b % 2 == 0);
            @(posedge clk);
            #1;
            check("bounce_dec", decrecer, 0);
            check("bounce_dh", down_held, 0);
            @(negedge clk);
        end
        btn_down = 1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check("bounce_final_dec", decrecer, int'(e == 6));
            check("bounce_final_dh", down_held, int'(e >= 6));
        end
        @(negedge clk);
        btn_down = 0;
        repeat (10) @(negedge clk);

        // asynchronous reset mid-run with btn_up held
        btn_up = 1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_rst_acr", acrescer, 0);
        check("async_rst_dec", decrecer, 0);
        check("async_rst_uh", up_held, 0);
        check("async_rst_dh", down_held, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check("post_rst_acr", acrescer, int'(e == 6));
            check("post_rst_uh", up_held, int'(e >= 6));
        end
        @(negedge clk);
        btn_up = 0;
        repeat (10) @(negedge clk);

        // randomized runs against the model
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(9) == 0) btn_up = ~btn_up;
            if ($urandom_range(9) == 0) btn_down = ~btn_down;
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
